// File: rtl/mipi_rx_lane_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mipi_rx_lane_ctrl                                            |
// | Description : MIPI D-PHY receive lane controller: HS entry detection,      |
// |               settle, sync-byte hunt and byte-aligned payload output.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mipi_rx_lane_ctrl #(
    parameter int SETTLE_CYCLES = 6,
    parameter int SYNC_TIMEOUT  = 64
) (
    input  logic       CLK_IN,
    input  logic       RST,
    input  logic       RX_LP_DP,
    input  logic       RX_LP_DN,
    input  logic [7:0] HS_RX_DATA,
    input  logic       HS_RX_DATA_VALID,
    output logic       HS_EN,
    output logic       RX_ODT_EN,
    output logic [7:0] RX_DATA,
    output logic       RX_DATA_VALID,
    output logic       RX_ACTIVE,
    output logic       RX_SYNC_ERR,
    output logic [1:0] LP_STATE
);

    typedef enum logic [2:0] {
        c_ST_STOP    = 3'd0,
        c_ST_HS_RQST = 3'd1,
        c_ST_HS_PREP = 3'd2,
        c_ST_HS_SYNC = 3'd3,
        c_ST_HS_DATA = 3'd4,
        c_ST_HS_ERR  = 3'd5
    } state_t;

    localparam logic [7:0] c_SYNC_BYTE    = 8'hB8;
    localparam logic [7:0] c_SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
    localparam logic [9:0] c_TIMEOUT_LAST = 10'(SYNC_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_lp_meta;
    logic [1:0]  r_lp_state;
    logic [7:0]  r_settle_cnt;
    logic [9:0]  r_timeout_cnt;
    logic [7:0]  r_prev;
    logic        r_prev_valid;
    logic [2:0]  r_offset;
    logic        r_hs_en;
    logic [7:0]  r_rx_data;
    logic        r_rx_data_valid;
    logic        r_rx_active;
    logic        r_sync_err;

    logic [14:0] w_window;
    logic        w_match;
    logic [2:0]  w_match_off;
    logic        w_hit;
    logic        w_timeout;
    logic        w_lp11;
    logic        w_emit;
    logic        w_sync_err_set;
    logic        w_hs_on;
    logic        w_enter_sync;

    // Top window bit can never be part of an 8-bit slice at offsets 0..7.
    assign w_window  = {HS_RX_DATA[6:0], r_prev};
    assign w_lp11    = (r_lp_state == 2'b11);
    assign w_hit     = HS_RX_DATA_VALID && r_prev_valid && w_match;
    assign w_timeout = HS_RX_DATA_VALID && (r_timeout_cnt == c_TIMEOUT_LAST);

    // Descending scan so the lowest matching offset is the one kept.
    always_comb begin
        w_match     = 1'b0;
        w_match_off = 3'd0;
        for (int o = 7; o >= 0; o--) begin
            if (w_window[o +: 8] == c_SYNC_BYTE) begin
                w_match     = 1'b1;
                w_match_off = 3'(o);
            end
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_emit         = 1'b0;
        w_sync_err_set = 1'b0;
        case (r_state)
            c_ST_STOP: begin
                if (r_lp_state == 2'b01) w_next_state = c_ST_HS_RQST;
            end
            c_ST_HS_RQST: begin
                if (r_lp_state == 2'b00)      w_next_state = c_ST_HS_PREP;
                else if (r_lp_state != 2'b01) w_next_state = c_ST_STOP;
            end
            c_ST_HS_PREP: begin
                if (r_lp_state != 2'b00)              w_next_state = c_ST_STOP;
                else if (r_settle_cnt == c_SETTLE_LAST) w_next_state = c_ST_HS_SYNC;
            end
            c_ST_HS_SYNC: begin
                if (w_lp11) begin
                    w_next_state = c_ST_STOP;
                end else if (w_hit) begin
                    w_next_state = c_ST_HS_DATA;
                end else if (w_timeout) begin
                    w_next_state   = c_ST_HS_ERR;
                    w_sync_err_set = 1'b1;
                end
            end
            c_ST_HS_DATA: begin
                if (w_lp11) w_next_state = c_ST_STOP;
                else        w_emit       = HS_RX_DATA_VALID;
            end
            c_ST_HS_ERR: begin
                if (w_lp11) w_next_state = c_ST_STOP;
            end
            default: w_next_state = c_ST_STOP;
        endcase
        w_hs_on      = (w_next_state == c_ST_HS_PREP) || (w_next_state == c_ST_HS_SYNC) ||
                       (w_next_state == c_ST_HS_DATA);
        w_enter_sync = (w_next_state == c_ST_HS_SYNC) && (r_state != c_ST_HS_SYNC);
    end

    always_ff @(posedge CLK_IN) begin
        if (!RST) begin
            r_state         <= c_ST_STOP;
            r_lp_meta       <= 2'b11;
            r_lp_state      <= 2'b11;
            r_settle_cnt    <= 8'd0;
            r_timeout_cnt   <= 10'd0;
            r_prev          <= 8'd0;
            r_prev_valid    <= 1'b0;
            r_offset        <= 3'd0;
            r_hs_en         <= 1'b0;
            r_rx_data       <= 8'd0;
            r_rx_data_valid <= 1'b0;
            r_rx_active     <= 1'b0;
            r_sync_err      <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_lp_meta  <= {RX_LP_DP, RX_LP_DN};
            r_lp_state <= r_lp_meta;

            if (r_state == c_ST_HS_PREP) r_settle_cnt <= r_settle_cnt + 8'd1;
            else                         r_settle_cnt <= 8'd0;

            if (w_enter_sync) begin
                r_prev        <= 8'd0;
                r_prev_valid  <= 1'b0;
                r_timeout_cnt <= 10'd0;
            end else if (HS_RX_DATA_VALID &&
                         ((r_state == c_ST_HS_SYNC) || (r_state == c_ST_HS_DATA))) begin
                r_prev       <= HS_RX_DATA;
                r_prev_valid <= 1'b1;
                if (r_state == c_ST_HS_SYNC) r_timeout_cnt <= r_timeout_cnt + 10'd1;
            end

            if ((r_state == c_ST_HS_SYNC) && w_hit) r_offset <= w_match_off;

            r_rx_data_valid <= w_emit;
            if (w_emit) r_rx_data <= w_window[r_offset +: 8];

            r_sync_err  <= w_sync_err_set;
            r_hs_en     <= w_hs_on;
            r_rx_active <= (w_next_state == c_ST_HS_DATA);
        end
    end

    assign HS_EN         = r_hs_en;
    assign RX_ODT_EN     = r_hs_en;
    assign RX_DATA       = r_rx_data;
    assign RX_DATA_VALID = r_rx_data_valid;
    assign RX_ACTIVE     = r_rx_active;
    assign RX_SYNC_ERR   = r_sync_err;
    assign LP_STATE      = r_lp_state;

endmodule
`default_nettype wire

// File: tb/tb_mipi_rx_lane_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mipi_rx_lane_ctrl                                         |
// | Description : Self-checking bench; payload expectations come from a        |
// |               bit-stream search for the sync byte.                         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mipi_rx_lane_ctrl;

    localparam int SETTLE  = 6;
    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lp_dp, lp_dn;
    logic [7:0] hs_data;
    logic       hs_valid;
    logic       hs_en, odt_en, rx_valid, rx_active, sync_err;
    logic [7:0] rx_data;
    logic [1:0] lp_state;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] last_byte;

    always #5 clk = ~clk;

    mipi_rx_lane_ctrl #(
        .SETTLE_CYCLES (SETTLE),
        .SYNC_TIMEOUT  (TIMEOUT)
    ) dut (
        .CLK_IN           (clk),
        .RST              (rst_n),
        .RX_LP_DP         (lp_dp),
        .RX_LP_DN         (lp_dn),
        .HS_RX_DATA       (hs_data),
        .HS_RX_DATA_VALID (hs_valid),
        .HS_EN            (hs_en),
        .RX_ODT_EN        (odt_en),
        .RX_DATA          (rx_data),
        .RX_DATA_VALID    (rx_valid),
        .RX_ACTIVE        (rx_active),
        .RX_SYNC_ERR      (sync_err),
        .LP_STATE         (lp_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lp(input logic [1:0] v);
        {lp_dp, lp_dn} = v;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_hs_en"},    hs_en,     0);
        check({tag, "_odt"},      odt_en,    0);
        check({tag, "_data"},     rx_data,   0);
        check({tag, "_valid"},    rx_valid,  0);
        check({tag, "_active"},   rx_active, 0);
        check({tag, "_sync_err"}, sync_err,  0);
        check({tag, "_lp_state"}, lp_state,  2'b11);
    endtask

    function automatic logic [7:0] byte_at(input bit q[$], input int idx);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = q[idx + j];
        return r;
    endfunction

    // From STOP with LP-11 settled: LP-01, LP-00, then sit through settle
    // while feeding sync-like junk that must be ignored.
    task automatic enter_hs();
        set_lp(2'b01);
        repeat (4) begin
            tick();
            check("rqst_hs_en_low", hs_en, 0);
        end
        set_lp(2'b00);
        tick(); check("entry_hs_en_e1", hs_en, 0);
        tick(); check("entry_hs_en_e2", hs_en, 0);
        tick(); check("entry_hs_en_e3", hs_en, 1);
        check("entry_odt_e3", odt_en, 1);
        hs_valid = 1'b1;
        hs_data  = 8'hB8;
        repeat (SETTLE) begin
            tick();
            check("prep_quiet", {rx_valid, rx_active}, 0);
        end
        hs_valid = 1'b0;
    endtask

    task automatic end_burst();
        set_lp(2'b11);
        tick();
        check("eob_hs_en_e1", hs_en, 1);
        check("eob_lp_e1", lp_state, 2'b00);
        check("eob_active_e1", rx_active, 1);
        tick();
        check("eob_hs_en_e2", hs_en, 1);
        check("eob_lp_e2", lp_state, 2'b11);
        tick();
        check("eob_hs_en_e3", hs_en, 0);
        check("eob_odt_e3", odt_en, 0);
        check("eob_active_e3", rx_active, 0);
        check("eob_valid_e3", rx_valid, 0);
        repeat (3) begin
            hs_valid = 1'b1;
            hs_data  = 8'($urandom);
            tick();
            check("post_eob_valid", rx_valid, 0);
            check("post_eob_hold", rx_data, last_byte);
        end
        hs_valid = 1'b0;
    endtask

    // Build a bit stream with a sync byte at bit position 8*k+o, find the
    // earliest sync occurrence, and expect each following 8-bit chunk one
    // cycle after the word that completes it.
    task automatic run_burst(input int o, input bit directed, input bit gaps, input bit end_rst);
        bit         bits[$];
        logic [7:0] sb, pb;
        int         pre, npay, p, d, nw, ng;
        sb   = 8'hB8;
        pre  = directed ? 8 + o : 8 * $urandom_range(1, 3) + o;
        npay = directed ? 3 : $urandom_range(1, 6);
        for (int i = 0; i < pre; i++) bits.push_back(directed ? 1'b0 : 1'($urandom_range(0, 1)));
        for (int i = 0; i < 8; i++) bits.push_back(sb[i]);
        for (int k = 0; k < npay; k++) begin
            if (directed) pb = (k == 0) ? 8'h5A : (k == 1) ? 8'hC3 : 8'hFF;
            else          pb = 8'($urandom);
            for (int i = 0; i < 8; i++) bits.push_back(pb[i]);
        end
        while (bits.size() % 8 != 0) bits.push_back(directed ? 1'b0 : 1'($urandom_range(0, 1)));
        nw = bits.size() / 8;
        p  = -1;
        for (int i = 0; i + 8 <= bits.size(); i++)
            if (p < 0 && byte_at(bits, i) == 8'hB8) p = i;
        d = (p < 0) ? nw : p / 8 + 1;

        enter_hs();
        for (int k = 0; k < nw; k++) begin
            ng = gaps ? $urandom_range(0, 2) : 0;
            for (int g = 0; g < ng; g++) begin
                hs_valid = 1'b0;
                hs_data  = 8'($urandom);
                tick();
                check("gap_valid", rx_valid, 0);
                check("gap_hold", rx_data, last_byte);
                check("gap_active", rx_active, k > d);
            end
            hs_valid = 1'b1;
            hs_data  = byte_at(bits, 8 * k);
            tick();
            if (k > d) begin
                last_byte = byte_at(bits, p + 8 * (k - d));
                check("payload_valid", rx_valid, 1);
                check("payload_byte", rx_data, last_byte);
            end else begin
                check("hunt_no_valid", rx_valid, 0);
            end
            check("burst_active", rx_active, k >= d);
            check("burst_no_err", sync_err, 0);
        end
        hs_valid = 1'b0;

        if (end_rst) begin
            hs_valid = 1'b1;
            hs_data  = 8'($urandom);
            rst_n    = 1'b0;
            tick();
            check_reset_vals("rst_in_data");
            last_byte = 8'h00;
            rst_n     = 1'b1;
            hs_valid  = 1'b0;
            tick();
            tick();
            check("rst_release_hs_en", hs_en, 0);
            check("rst_release_active", rx_active, 0);
            set_lp(2'b11);
            repeat (3) tick();
        end else begin
            end_burst();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        last_byte = 8'h00;
        rst_n     = 1'b0;
        hs_valid  = 1'b0;
        hs_data   = 8'h00;
        set_lp(2'b11);

        // Reset held with random inputs
        repeat (5) begin
            {lp_dp, lp_dn} = 2'($urandom);
            hs_data        = 8'($urandom);
            hs_valid       = 1'($urandom);
            tick();
            check_reset_vals("reset_hold");
        end
        set_lp(2'b11);
        hs_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (4) begin
            tick();
            check("post_reset_hs_en", hs_en, 0);
            check("post_reset_lp", lp_state, 2'b11);
        end

        // Abort LP-01 -> LP-11: HS never enabled
        set_lp(2'b01);
        repeat (4) tick();
        set_lp(2'b11);
        repeat (6) begin
            tick();
            check("abort01_hs_en", hs_en, 0);
        end

        // Directed alignment at offsets 3, 0, 7
        run_burst(3, 1'b1, 1'b0, 1'b0);
        run_burst(0, 1'b1, 1'b0, 1'b0);
        run_burst(7, 1'b1, 1'b0, 1'b0);

        // Randomized bursts with valid gaps
        for (int it = 0; it < 8; it++) run_burst($urandom_range(0, 7), 1'b0, 1'b1, 1'b0);

        // Sync match in the same cycle LP-11 is seen: LP-11 wins
        enter_hs();
        set_lp(2'b11);
        tick();
        hs_valid = 1'b1;
        hs_data  = 8'hB8;
        tick();
        check("lp11_race_hs_en_before", hs_en, 1);
        hs_data = 8'h00;
        tick();
        check("lp11_race_active", rx_active, 0);
        check("lp11_race_hs_en", hs_en, 0);
        check("lp11_race_valid", rx_valid, 0);
        hs_valid = 1'b0;
        repeat (2) tick();

        // Sync timeout
        enter_hs();
        hs_valid = 1'b1;
        hs_data  = 8'h00;
        for (int k = 0; k < TIMEOUT; k++) begin
            tick();
            if (k < TIMEOUT - 1) begin
                check("timeout_no_err", sync_err, 0);
                check("timeout_hs_en_hold", hs_en, 1);
            end else begin
                check("timeout_err_pulse", sync_err, 1);
                check("timeout_hs_en_drop", hs_en, 0);
                check("timeout_odt_drop", odt_en, 0);
            end
        end
        hs_valid = 1'b0;
        tick();
        check("timeout_err_one_cycle", sync_err, 0);
        // Still in the error state: an LP-01/00 sequence must not re-enable HS
        set_lp(2'b01);
        repeat (4) begin
            tick();
            check("err_wait_hs_en", hs_en, 0);
        end
        set_lp(2'b00);
        repeat (6) begin
            tick();
            check("err_wait_hs_en", hs_en, 0);
        end
        set_lp(2'b11);
        repeat (3) tick();
        check("err_exit_hs_en", hs_en, 0);
        enter_hs();
        set_lp(2'b11);
        repeat (3) tick();
        check("err_recovered_hs_en", hs_en, 0);

        // LP-10 during settle aborts to STOP
        set_lp(2'b01);
        repeat (4) tick();
        set_lp(2'b00);
        repeat (3) tick();
        check("prep_abort_hs_en_on", hs_en, 1);
        tick();
        set_lp(2'b10);
        tick(); check("prep_abort_e1", hs_en, 1);
        tick(); check("prep_abort_e2", hs_en, 1);
        tick(); check("prep_abort_e3", hs_en, 0);
        set_lp(2'b11);
        repeat (3) begin
            tick();
            check("prep_abort_stop", hs_en, 0);
        end

        // Reset pulse while in HS_DATA
        run_burst(5, 1'b1, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mipi_rx_lane_ctrl.md
# mipi_rx_lane_ctrl

Lane-level protocol controller for the MIPI D-PHY receive path. It is the counterpart of the transmit lane. It sits in the fabric clock domain between the LP line receivers plus HS deserializer and the packet layer. It watches the LP line state for the HS-request sequence, enables the HS receiver and termination, hunts for the HS sync byte in the deserialized stream, and outputs byte-aligned payload until the lane returns to LP-11.

## Interface
Parameters:
- SETTLE_CYCLES, 6: CLK_IN cycles spent in LP-00 before sync hunting starts (HS settle); legal range 1..255.
- SYNC_TIMEOUT, 64: valid HS words allowed without finding sync before an error is flagged; legal range 1..1023.

Ports:
- CLK_IN  input  1  fabric/word clock; all logic is on its rising edge.
- RST  input  1  synchronous, active-low reset.
- RX_LP_DP  input  1  LP receiver output, P line (asynchronous).
- RX_LP_DN  input  1  LP receiver output, N line (asynchronous).
- HS_RX_DATA  input  8  deserialized HS word; bit 0 is the earliest received bit.
- HS_RX_DATA_VALID  input  1  HS_RX_DATA is valid this cycle.
- HS_EN  output  1  enable for the HS receiver/deserializer.
- RX_ODT_EN  output  1  enable for the differential termination.
- RX_DATA  output  8  aligned payload byte; bit 0 is first on the wire.
- RX_DATA_VALID  output  1  RX_DATA is valid this cycle.
- RX_ACTIVE  output  1  high while in HS_DATA.
- RX_SYNC_ERR  output  1  one-cycle pulse on sync timeout.
- LP_STATE  output  2  synchronized {DP,DN}.

## Operation
- LP inputs pass through a 2-flop synchronizer that resets to 2'b11. LP_STATE is the second flop. All FSM decisions use LP_STATE.
- FSM states: STOP, HS_RQST, HS_PREP, HS_SYNC, HS_DATA, HS_ERR.
  - STOP: LP_STATE 01 moves to HS_RQST. Any other value stays in STOP. Escape mode and ULPS are not supported.
  - HS_RQST: 00 moves to HS_PREP and clears the settle counter. 01 stays. 11 or 10 returns to STOP with no error.
  - HS_PREP: the settle counter increments every cycle. When the count reaches SETTLE_CYCLES-1, the FSM moves to HS_SYNC. Any LP_STATE other than 00 returns to STOP.
  - HS_SYNC: described under sync hunt below. LP_STATE 11 returns to STOP.
  - HS_DATA: each valid input word produces one aligned output byte. LP_STATE 11 returns to STOP. This block does not strip the trailer.
  - HS_ERR: HS_EN and RX_ODT_EN are low. The FSM waits for LP_STATE 11, then moves to STOP.
- HS_EN and RX_ODT_EN are registered. Both are high exactly when the state is HS_PREP, HS_SYNC or HS_DATA.
- Sync hunt:
  - On entry to HS_SYNC, the prev register, prev_valid and the timeout counter are cleared.
  - On each valid word, form window = {HS_RX_DATA, prev}. If prev_valid=1 and window[o+7:o] == 8'hB8 for some o in 0..7, latch offset o (lowest o wins) and move to HS_DATA. The sync byte is never output.
  - Every valid word updates prev and sets prev_valid. Words that arrive while prev_valid=0 are never matched.
  - The timeout counter counts valid words. When it reaches SYNC_TIMEOUT with no match, RX_SYNC_ERR pulses and the FSM moves to HS_ERR.
- HS_DATA: on each valid word, RX_DATA is registered from {HS_RX_DATA, prev}[off+7:off], RX_DATA_VALID is set to 1, and prev is updated.
- RX_DATA holds its last value when not valid. It is cleared only by reset.

## Timing
- Reset values: HS_EN=0, RX_ODT_EN=0, RX_DATA=8'h00, RX_DATA_VALID=0, RX_ACTIVE=0, RX_SYNC_ERR=0, LP_STATE=2'b11, FSM in STOP, all counters and offset 0.
- Reset taking effect mid-operation, including in HS_DATA: every output takes its reset value on that same edge. No partial byte is emitted.
- LP input change to LP_STATE: 2 edges. To a state change: 3 edges. HS_EN rises on the 3rd edge after LP-00 is applied (with LP-01 already held long enough to reach HS_RQST).
- From HS_PREP entry to HS_SYNC: SETTLE_CYCLES edges.
- Data latency: RX_DATA_VALID is high in the cycle after the input valid cycle, giving 1-cycle latency. Gaps in HS_RX_DATA_VALID are reproduced in RX_DATA_VALID.
- Sync match and LP-11 in the same cycle: LP-11 wins, and the FSM goes to STOP.
- Timeout and match on the same word: the match wins.
- RX_ACTIVE follows the registered state. It falls on the edge that leaves HS_DATA, together with HS_EN.

## Test plan
- Reset: hold RST=0 with random inputs. Every output equals its reset value. Then release RST with the LP lines at 11; the FSM stays in STOP with HS_EN=0.
- HS entry: apply LP 11 → 01 (held 4 cycles) → 00. HS_EN and RX_ODT_EN rise on the 3rd edge after 00. With SETTLE_CYCLES=6, hunting starts 6 edges later.
- Alignment: after settle, feed 0x00, then B8 at bit offset 3, then payload 0x5A, 0xC3, 0xFF. RX_DATA shows 0x5A, 0xC3, 0xFF on consecutive valid cycles with 1-cycle latency and RX_ACTIVE=1. Repeat for offsets 0 and 7.
- End of burst: in HS_DATA, apply LP-11. HS_EN, RX_ODT_EN and RX_ACTIVE fall 3 edges later, and no RX_DATA_VALID follows.
- Timeout: with SYNC_TIMEOUT=64, feed 64 valid 0x00 words. RX_SYNC_ERR pulses for exactly one cycle on the 64th word and HS_EN drops. The FSM returns to STOP only after LP-11.
- Aborts:
  - LP 01 → 11 returns to STOP with HS_EN never asserted.
  - LP-10 during HS_PREP returns to STOP.
  - RST pulsed in HS_DATA gives reset values on the next edge.
